// File: rtl/prog_loader.sv
// Debug program loader: turns a host byte stream (count header + words, LSB first)
// into instruction-memory writes and keeps the core in reset while the load runs.
module prog_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 1024,
  parameter int unsigned TIMEOUT   = 100000
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        DEBUG_SIG,
  output logic [31:0] DEBUG_addr,
  output logic [31:0] DEBUG_instr,
  output logic        clk_debug,
  output logic        core_nrst,
  output logic        load_done,
  output logic        err_len,
  output logic        err_timeout
);

  localparam int unsigned GapW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, LEN, DATA, STRB, HOLD, DONE} state_e;

  state_e            state_q, state_d;
  logic              rx_ready_q, rx_ready_d;
  logic              sig_q, sig_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       instr_q, instr_d;
  logic              strobe_q, strobe_d;
  logic              core_nrst_q, core_nrst_d;
  logic              done_q, done_d;
  logic              err_len_q, err_len_d;
  logic              err_to_q, err_to_d;
  logic              held_q, held_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [31:0]       index_q, index_d;
  logic [31:0]       count_q, count_d;
  logic [23:0]       word_q, word_d;
  logic [GapW-1:0]   gap_q, gap_d;

  logic        accept;
  logic        gap_hit;
  logic [31:0] count_full;
  logic [31:0] word_full;
  logic [31:0] idx_next;

  assign accept     = rx_valid && rx_ready_q;
  assign gap_hit    = (gap_q == GapW'(TIMEOUT - 1));
  assign count_full = {rx_data, count_q[23:0]};
  assign word_full  = {rx_data, word_q};
  assign idx_next   = index_q + 32'd1;

  // held_q remembers an aborted load so the core stays in reset until a full image lands
  always_comb begin
    state_d     = state_q;
    rx_ready_d  = rx_ready_q;
    sig_d       = sig_q;
    addr_d      = addr_q;
    instr_d     = instr_q;
    strobe_d    = 1'b0;
    core_nrst_d = core_nrst_q;
    done_d      = 1'b0;
    err_len_d   = err_len_q;
    err_to_d    = err_to_q;
    held_d      = held_q;
    bcnt_d      = bcnt_q;
    index_d     = index_q;
    count_d     = count_q;
    word_d      = word_q;
    gap_d       = gap_q;

    case (state_q)
      IDLE: begin
        rx_ready_d = 1'b1;
        gap_d      = '0;
        if (accept) begin
          count_d     = {24'd0, rx_data};
          bcnt_d      = 2'd1;
          state_d     = LEN;
          core_nrst_d = 1'b0;
          sig_d       = 1'b1;
        end else begin
          core_nrst_d = !held_q;
        end
      end
      LEN: begin
        if (accept) begin
          count_d[{bcnt_q, 3'b000} +: 8] = rx_data;
          bcnt_d = bcnt_q + 2'd1;
          gap_d  = '0;
          if (bcnt_q == 2'd3) begin
            if (count_full == 32'd0) begin
              state_d    = DONE;
              done_d     = 1'b1;
              sig_d      = 1'b0;
              rx_ready_d = 1'b0;
            end else if (count_full > MAX_WORDS) begin
              state_d   = IDLE;
              err_len_d = 1'b1;
              sig_d     = 1'b0;
              held_d    = 1'b1;
            end else begin
              state_d = DATA;
              index_d = '0;
            end
          end
        end else if (gap_hit) begin
          state_d  = IDLE;
          err_to_d = 1'b1;
          sig_d    = 1'b0;
          held_d   = 1'b1;
          bcnt_d   = '0;
          gap_d    = '0;
        end else begin
          gap_d = gap_q + GapW'(1);
        end
      end
      DATA: begin
        if (accept) begin
          word_d = word_full[31:8];
          bcnt_d = bcnt_q + 2'd1;
          gap_d  = '0;
          if (bcnt_q == 2'd3) begin
            instr_d    = word_full;
            addr_d     = BASE_ADDR + {index_q[29:0], 2'b00};
            state_d    = STRB;
            rx_ready_d = 1'b0;
          end
        end else if (gap_hit) begin
          state_d  = IDLE;
          err_to_d = 1'b1;
          sig_d    = 1'b0;
          held_d   = 1'b1;
          bcnt_d   = '0;
          gap_d    = '0;
        end else begin
          gap_d = gap_q + GapW'(1);
        end
      end
      STRB: begin
        strobe_d = 1'b1;
        state_d  = HOLD;
      end
      HOLD: begin
        index_d = idx_next;
        if (idx_next == count_q) begin
          state_d = DONE;
          done_d  = 1'b1;
          sig_d   = 1'b0;
        end else begin
          state_d    = DATA;
          rx_ready_d = 1'b1;
        end
      end
      DONE: begin
        core_nrst_d = 1'b1;
        held_d      = 1'b0;
        rx_ready_d  = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      rx_ready_q  <= 1'b0;
      sig_q       <= 1'b0;
      addr_q      <= BASE_ADDR;
      instr_q     <= '0;
      strobe_q    <= 1'b0;
      core_nrst_q <= 1'b0;
      done_q      <= 1'b0;
      err_len_q   <= 1'b0;
      err_to_q    <= 1'b0;
      held_q      <= 1'b0;
      bcnt_q      <= '0;
      index_q     <= '0;
      count_q     <= '0;
      word_q      <= '0;
      gap_q       <= '0;
    end else begin
      state_q     <= state_d;
      rx_ready_q  <= rx_ready_d;
      sig_q       <= sig_d;
      addr_q      <= addr_d;
      instr_q     <= instr_d;
      strobe_q    <= strobe_d;
      core_nrst_q <= core_nrst_d;
      done_q      <= done_d;
      err_len_q   <= err_len_d;
      err_to_q    <= err_to_d;
      held_q      <= held_d;
      bcnt_q      <= bcnt_d;
      index_q     <= index_d;
      count_q     <= count_d;
      word_q      <= word_d;
      gap_q       <= gap_d;
    end
  end

  assign rx_ready    = rx_ready_q;
  assign DEBUG_SIG   = sig_q;
  assign DEBUG_addr  = addr_q;
  assign DEBUG_instr = instr_q;
  assign clk_debug   = strobe_q;
  assign core_nrst   = core_nrst_q;
  assign load_done   = done_q;
  assign err_len     = err_len_q;
  assign err_timeout = err_to_q;

endmodule
